wb_trace_checker: RTL and testbench
===================================

# wb_trace_checker

Synthesizable retire-trace checker that consumes the CPU's writeback debug interface (`debug_wb_pc` / `debug_wb_rf_we` / `debug_wb_rf_wnum` / `debug_wb_rf_wdata`). It compares each register-file write against a golden-trace stream delivered over a valid/ready handshake. It sits beside `mycpu_top` in the SoC/FPGA wrapper and reports pass/fail without a simulator. It buffers writeback events in a small FIFO, because the CPU cannot be stalled by the checker.

## Interface
Parameters:
- `FIFO_DEPTH`, 8, writeback-event buffer entries (power of two, ≥2)
- `END_PC`, 32'h1c000100, PC whose appearance on `debug_wb_pc` marks end of test

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high
- `debug_wb_pc`  in  32  PC of instruction in writeback
- `debug_wb_rf_we`  in  4  byte write enables of the register-file write
- `debug_wb_rf_wnum`  in  5  destination register
- `debug_wb_rf_wdata`  in  32  write data
- `gold_valid`  in  1  golden entry available
- `gold_ready`  out  1  golden entry consumed this cycle
- `gold_pc`  in  32  expected PC
- `gold_wnum`  in  5  expected register
- `gold_wdata`  in  32  expected data
- `mismatch`  out  1  sticky compare failure
- `overflow`  out  1  sticky event-FIFO overflow
- `err_pc`  out  32  DUT PC of the failing event
- `err_wnum`  out  5  DUT register of the failing event
- `err_wdata`  out  32  masked DUT data of the failing event
- `err_gold_wdata`  out  32  masked golden data of the failing compare
- `match_count`  out  32  number of successful compares
- `test_done`  out  1  end reached, FIFO drained, no error
- `test_pass`  out  1  `test_done & ~mismatch & ~overflow`

## Operation
- Event capture: an event occurs in a cycle where `|debug_wb_rf_we` is 1 and `debug_wb_rf_wnum` is not 0. Writes to r0 are ignored.
- Stored per event: pc, wnum, and `mask`, where `mask` is `debug_wb_rf_we` expanded per byte to 32 bits. The stored data is `wdata & mask`.
- FSM states: RUN, ERROR, DONE. Reset enters RUN.
- RUN:
  - `gold_ready` is 1 exactly when the FIFO is not empty. It is combinational from the FIFO count and the state only, not from `gold_valid`.
  - Compare fires when `gold_valid & gold_ready`. The FIFO head is popped and the golden entry is consumed.
  - The compare passes when pc matches, wnum matches, and `(gold_wdata & head.mask) == head.wdata`.
  - On pass: `match_count` increments, wrapping at 2^32.
  - On fail: latch the `err_*` registers, set `mismatch`, go to ERROR.
- Overflow: a push while the FIFO is full and no pop happens in the same cycle sets `overflow` and goes to ERROR. The event is dropped. A push and a pop in the same cycle at full are legal: the count stays at `FIFO_DEPTH` and no overflow occurs.
- End detect: `debug_wb_pc == END_PC` in any cycle sets the sticky `end_seen` flag. When `end_seen` is set and the FIFO is empty at the start of a cycle in RUN, go to DONE. An event captured in the same cycle as `END_PC` is still pushed and checked before DONE.
- ERROR: terminal state.
  - `gold_ready` = 0, captures are ignored, `err_*` hold.
  - `test_done` = 0, `test_pass` = 0.
- DONE: terminal state.
  - `gold_ready` = 0, `test_done` = 1, captures are ignored.
- A simultaneous mismatch and overflow in the same cycle sets both flags. `err_*` take the compare values.
- All outputs and state are reset to 0, with `mismatch`/`overflow`/`end_seen` cleared and the FIFO emptied. A reset mid-test discards buffered events.

## Timing
- An event present on the debug ports in cycle N is written to the FIFO at the rising edge ending cycle N.
- The earliest compare for that event is cycle N+1 (`gold_ready` = 1 in N+1).
- A compare in cycle M updates `match_count`, `mismatch`, `err_*` and the state at the edge ending M. They are visible in M+1.
- Throughput: one compare per cycle sustained.
- Golden stalls (`gold_valid` = 0) are tolerated until the FIFO holds `FIFO_DEPTH` entries. The next capture without a pop overflows.
- `test_done` asserts one cycle after the first cycle in which `end_seen` and FIFO-empty are both true. If `END_PC` appears with an empty FIFO in cycle N, `end_seen` is set at the end of N and `test_done` = 1 in N+2.

## Test plan
- Three writebacks (pc 1c000000/04/08, r4/r5/r6, data 1/2/3) with matching golden entries presented continuously → `gold_ready` pulses one cycle after each event, `match_count` = 3, `mismatch` = 0.
- Event r4 = 0x12345678 against golden 0x12345679 → `mismatch` = 1 the cycle after the compare, `err_wnum` = 4, `err_wdata` = 0x12345678, `err_gold_wdata` = 0x12345679, `gold_ready` then stays 0.
- Byte write (`we` = 4'b0001, wdata 0xAABBCC11) against golden 0xFFFFFF11 → pass, because only the low byte is compared. A write to r0 produces no FIFO push.
- `gold_valid` held 0 for 8 events, 9th event → `overflow` = 1, state ERROR. Variant: 9th event coincides with a pop → no overflow.
- `END_PC` appears while 2 events are pending → `test_done` stays 0 until both are compared, then becomes 1, `test_pass` = 1.
- Reset asserted mid-run with 3 buffered events and `match_count` = 5 → next cycle all outputs are 0, FIFO empty, `gold_ready` = 0.

Source files
------------

// File: rtl/wb_trace_checker.sv
// wb_trace_checker: compares CPU register-file writebacks against a golden
// trace stream. Writeback events are buffered in a small FIFO because the CPU
// cannot be stalled; the golden side is consumed through a valid/ready pair.
module wb_trace_checker #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] END_PC     = 32'h1c000100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_we,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  input  logic        gold_valid,
  output logic        gold_ready,
  input  logic [31:0] gold_pc,
  input  logic [4:0]  gold_wnum,
  input  logic [31:0] gold_wdata,
  output logic        mismatch,
  output logic        overflow,
  output logic [31:0] err_pc,
  output logic [4:0]  err_wnum,
  output logic [31:0] err_wdata,
  output logic [31:0] err_gold_wdata,
  output logic [31:0] match_count,
  output logic        test_done,
  output logic        test_pass
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ERROR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Expand per-byte write enables to a 32-bit data mask.
  function automatic logic [31:0] expand_we(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

  state_t state_r, state_nx;

  logic [31:0] fifo_pc_r   [FIFO_DEPTH];
  logic [4:0]  fifo_wnum_r [FIFO_DEPTH];
  logic [31:0] fifo_mask_r [FIFO_DEPTH];
  logic [31:0] fifo_data_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic end_seen_r;

  logic [31:0] head_pc_s, head_mask_s, head_data_s, cap_mask_s;
  logic [4:0]  head_wnum_s;
  logic run_s, empty_s, full_s, capture_s, pop_s, push_s, ovf_s;
  logic cmp_ok_s, cmp_pass_s, cmp_fail_s;

  assign run_s       = (state_r == ST_RUN);
  assign empty_s     = (count_r == {CW{1'b0}});
  assign full_s      = (count_r == FULL_CNT);
  assign capture_s   = (|debug_wb_rf_we) && (debug_wb_rf_wnum != 5'd0);
  assign cap_mask_s  = expand_we(debug_wb_rf_we);
  assign head_pc_s   = fifo_pc_r[rd_ptr_r];
  assign head_wnum_s = fifo_wnum_r[rd_ptr_r];
  assign head_mask_s = fifo_mask_r[rd_ptr_r];
  assign head_data_s = fifo_data_r[rd_ptr_r];

  // Ready depends only on state and occupancy, never on gold_valid.
  assign gold_ready  = run_s && !empty_s;
  assign pop_s       = gold_valid && gold_ready;
  assign cmp_ok_s    = (gold_pc == head_pc_s) && (gold_wnum == head_wnum_s) &&
                       ((gold_wdata & head_mask_s) == head_data_s);
  assign cmp_pass_s  = pop_s && cmp_ok_s;
  assign cmp_fail_s  = pop_s && !cmp_ok_s;
  // A push at full is legal only when the head leaves in the same cycle.
  assign push_s      = run_s && capture_s && (!full_s || pop_s);
  assign ovf_s       = run_s && capture_s && full_s && !pop_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_RUN;
    else       state_r <= state_nx;
  end

  // FSM next state: errors win over end-of-test; ERROR and DONE are terminal.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      ST_RUN: begin
        if (cmp_fail_s || ovf_s)         state_nx = ST_ERROR;
        else if (end_seen_r && empty_s)  state_nx = ST_DONE;
        else                             state_nx = ST_RUN;
      end
      ST_ERROR: state_nx = ST_ERROR;
      ST_DONE:  state_nx = ST_DONE;
      default:  state_nx = ST_RUN;
    endcase
  end

  // FIFO storage; entries are written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_pc_r[wr_ptr_r]   <= debug_wb_pc;
      fifo_wnum_r[wr_ptr_r] <= debug_wb_rf_wnum;
      fifo_mask_r[wr_ptr_r] <= cap_mask_s;
      fifo_data_r[wr_ptr_r] <= debug_wb_rf_wdata & cap_mask_s;
    end
  end

  // FIFO pointers and occupancy; reset discards buffered events.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky end-of-test marker, set whenever END_PC retires.
  always_ff @(posedge clk) begin
    if (reset)                        end_seen_r <= 1'b0;
    else if (debug_wb_pc == END_PC)   end_seen_r <= 1'b1;
  end

  // Compare results: match counter, sticky error flags and failing-event capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch       <= 1'b0;
      overflow       <= 1'b0;
      err_pc         <= 32'd0;
      err_wnum       <= 5'd0;
      err_wdata      <= 32'd0;
      err_gold_wdata <= 32'd0;
      match_count    <= 32'd0;
    end else if (run_s) begin
      if (cmp_pass_s) match_count <= match_count + 32'd1;
      if (cmp_fail_s) begin
        mismatch       <= 1'b1;
        err_pc         <= head_pc_s;
        err_wnum       <= head_wnum_s;
        err_wdata      <= head_data_s;
        err_gold_wdata <= gold_wdata & head_mask_s;
      end
      if (ovf_s) overflow <= 1'b1;
    end
  end

  // Completion outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      test_done <= 1'b0;
      test_pass <= 1'b0;
    end else begin
      test_done <= (state_nx == ST_DONE);
      test_pass <= (state_nx == ST_DONE) && !mismatch && !overflow;
    end
  end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed testbench for wb_trace_checker. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the rising edge that used them.
module tb_wb_trace_checker;

  localparam logic [31:0] END_PC = 32'h1c000100;

  logic        clk;
  logic        reset;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        gold_valid;
  logic        gold_ready;
  logic [31:0] gold_pc;
  logic [4:0]  gold_wnum;
  logic [31:0] gold_wdata;
  logic        mismatch;
  logic        overflow;
  logic [31:0] err_pc;
  logic [4:0]  err_wnum;
  logic [31:0] err_wdata;
  logic [31:0] err_gold_wdata;
  logic [31:0] match_count;
  logic        test_done;
  logic        test_pass;

  int vectors;
  int miscompares;

  wb_trace_checker #(.FIFO_DEPTH(8), .END_PC(END_PC)) dut (
    .clk(clk), .reset(reset),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .gold_valid(gold_valid), .gold_ready(gold_ready),
    .gold_pc(gold_pc), .gold_wnum(gold_wnum), .gold_wdata(gold_wdata),
    .mismatch(mismatch), .overflow(overflow),
    .err_pc(err_pc), .err_wnum(err_wnum), .err_wdata(err_wdata),
    .err_gold_wdata(err_gold_wdata), .match_count(match_count),
    .test_done(test_done), .test_pass(test_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers (no checking inside).
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_ev();
    debug_wb_pc       = 32'h0;
    debug_wb_rf_we    = 4'h0;
    debug_wb_rf_wnum  = 5'd0;
    debug_wb_rf_wdata = 32'h0;
  endtask

  task automatic set_ev(input logic [31:0] pc, input logic [3:0] we,
                        input logic [4:0] wn, input logic [31:0] wd);
    debug_wb_pc = pc; debug_wb_rf_we = we; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd;
  endtask

  task automatic set_gold(input logic v, input logic [31:0] pc,
                          input logic [4:0] wn, input logic [31:0] wd);
    gold_valid = v; gold_pc = pc; gold_wnum = wn; gold_wdata = wd;
  endtask

  // Indexed trace entry i: pc 1c000000+4i, register i+1, data i+1.
  task automatic put_ev(input int i);
    set_ev(32'h1c000000 + 32'(4 * i), 4'hf, 5'(i + 1), 32'(i + 1));
  endtask

  task automatic put_gold(input int i);
    set_gold(1'b1, 32'h1c000000 + 32'(4 * i), 5'(i + 1), 32'(i + 1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_ev();
    set_gold(1'b0, 32'h0, 5'd0, 32'h0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({gold_ready, mismatch, overflow, test_done, test_pass} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp 00000", {gold_ready, mismatch, overflow, test_done, test_pass});
    end
    vectors++;
    if ({err_pc, err_wnum, err_wdata, err_gold_wdata, match_count} !== 133'd0) begin
      miscompares++;
      $display("FAIL reset_regs got nonzero mc=%h err_pc=%h exp 0", match_count, err_pc);
    end
  endtask

  task automatic test_basic();
    do_reset();
    put_ev(0); put_gold(0);
    step();
    vectors++;
    if (gold_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready1 got %b exp 1", gold_ready); end
    put_ev(1);
    step();
    vectors++;
    if (match_count !== 32'd1) begin miscompares++; $display("FAIL basic_mc1 got %0d exp 1", match_count); end
    put_ev(2); put_gold(1);
    step();
    vectors++;
    if (match_count !== 32'd2 || gold_ready !== 1'b1) begin
      miscompares++; $display("FAIL basic_mc2 got mc=%0d rdy=%b exp mc=2 rdy=1", match_count, gold_ready);
    end
    idle_ev(); put_gold(2);
    step();
    vectors++;
    if (match_count !== 32'd3 || mismatch !== 1'b0 || gold_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_mc3 got mc=%0d mm=%b rdy=%b exp mc=3 mm=0 rdy=0", match_count, mismatch, gold_ready);
    end
    gold_valid = 1'b0;
  endtask

  task automatic test_mismatch();
    do_reset();
    set_ev(32'h1c000000, 4'hf, 5'd4, 32'h12345678);
    set_gold(1'b1, 32'h1c000000, 5'd4, 32'h12345679);
    step();
    idle_ev();
    step();
    vectors++;
    if (mismatch !== 1'b1 || err_wnum !== 5'd4 || err_pc !== 32'h1c000000) begin
      miscompares++;
      $display("FAIL mm_flag got mm=%b wnum=%0d pc=%h exp 1 4 1c000000", mismatch, err_wnum, err_pc);
    end
    vectors++;
    if (err_wdata !== 32'h12345678 || err_gold_wdata !== 32'h12345679) begin
      miscompares++;
      $display("FAIL mm_data got %h/%h exp 12345678/12345679", err_wdata, err_gold_wdata);
    end
    put_ev(5);
    step();
    vectors++;
    if (gold_ready !== 1'b0 || match_count !== 32'd0 || test_done !== 1'b0 || err_wnum !== 5'd4) begin
      miscompares++;
      $display("FAIL mm_error_hold got rdy=%b mc=%0d td=%b wnum=%0d exp 0 0 0 4", gold_ready, match_count, test_done, err_wnum);
    end
    gold_valid = 1'b0;
  endtask

  task automatic test_byte_mask();
    do_reset();
    set_ev(32'h1c000010, 4'b0001, 5'd7, 32'haabbcc11);
    set_gold(1'b1, 32'h1c000010, 5'd7, 32'hffffff11);
    step();
    set_ev(32'h1c000014, 4'hf, 5'd0, 32'hdeadbeef);
    step();
    vectors++;
    if (match_count !== 32'd1 || mismatch !== 1'b0) begin
      miscompares++; $display("FAIL byte_pass got mc=%0d mm=%b exp 1 0", match_count, mismatch);
    end
    vectors++;
    if (gold_ready !== 1'b0) begin miscompares++; $display("FAIL r0_nopush got rdy=%b exp 0", gold_ready); end
    idle_ev(); gold_valid = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin put_ev(i); step(); end
    vectors++;
    if (overflow !== 1'b0 || gold_ready !== 1'b1) begin
      miscompares++; $display("FAIL ovf_full got ovf=%b rdy=%b exp 0 1", overflow, gold_ready);
    end
    put_ev(8);
    step();
    idle_ev();
    vectors++;
    if (overflow !== 1'b1 || gold_ready !== 1'b0 || mismatch !== 1'b0) begin
      miscompares++; $display("FAIL ovf_set got ovf=%b rdy=%b mm=%b exp 1 0 0", overflow, gold_ready, mismatch);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) begin put_ev(i); step(); end
    put_ev(8); put_gold(0);
    step();
    idle_ev();
    vectors++;
    if (overflow !== 1'b0 || match_count !== 32'd1 || gold_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_pushpop got ovf=%b mc=%0d rdy=%b exp 0 1 1", overflow, match_count, gold_ready);
    end
    for (int k = 1; k < 9; k++) begin put_gold(k); step(); end
    gold_valid = 1'b0;
    vectors++;
    if (match_count !== 32'd9 || gold_ready !== 1'b0 || mismatch !== 1'b0) begin
      miscompares++;
      $display("FAIL drain got mc=%0d rdy=%b mm=%b exp 9 0 0", match_count, gold_ready, mismatch);
    end
  endtask

  task automatic test_end();
    do_reset();
    put_ev(0); step();
    put_ev(1); step();
    set_ev(END_PC, 4'h0, 5'd0, 32'h0);
    step();
    idle_ev();
    vectors++;
    if (test_done !== 1'b0) begin miscompares++; $display("FAIL end_pending got td=%b exp 0", test_done); end
    put_gold(0); step();
    put_gold(1); step();
    gold_valid = 1'b0;
    vectors++;
    if (test_done !== 1'b0 || match_count !== 32'd2) begin
      miscompares++; $display("FAIL end_drained got td=%b mc=%0d exp 0 2", test_done, match_count);
    end
    step();
    vectors++;
    if (test_done !== 1'b1 || test_pass !== 1'b1 || gold_ready !== 1'b0) begin
      miscompares++; $display("FAIL end_done got td=%b tp=%b rdy=%b exp 1 1 0", test_done, test_pass, gold_ready);
    end
    // END_PC with an empty FIFO: done two cycles later.
    do_reset();
    set_ev(END_PC, 4'h0, 5'd0, 32'h0);
    step();
    idle_ev();
    vectors++;
    if (test_done !== 1'b0) begin miscompares++; $display("FAIL end_empty_n1 got td=%b exp 0", test_done); end
    step();
    vectors++;
    if (test_done !== 1'b1 || test_pass !== 1'b1) begin
      miscompares++; $display("FAIL end_empty_n2 got td=%b tp=%b exp 1 1", test_done, test_pass);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    put_ev(0); step();
    for (int i = 1; i < 5; i++) begin put_ev(i); put_gold(i - 1); step(); end
    idle_ev(); put_gold(4); step();
    gold_valid = 1'b0;
    for (int i = 5; i < 8; i++) begin put_ev(i); step(); end
    idle_ev();
    vectors++;
    if (match_count !== 32'd5 || gold_ready !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset got mc=%0d rdy=%b exp 5 1", match_count, gold_ready);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if ({gold_ready, mismatch, overflow, test_done, test_pass} !== 5'b0 || match_count !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset got flags=%b mc=%0d exp 00000 0",
               {gold_ready, mismatch, overflow, test_done, test_pass}, match_count);
    end
    put_gold(5);
    step();
    gold_valid = 1'b0;
    vectors++;
    if (gold_ready !== 1'b0 || match_count !== 32'd0 || mismatch !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flushed got rdy=%b mc=%0d mm=%b exp 0 0 0", gold_ready, match_count, mismatch);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    idle_ev();
    set_gold(1'b0, 32'h0, 5'd0, 32'h0);
    test_reset();
    test_basic();
    test_mismatch();
    test_byte_mask();
    test_overflow();
    test_back_to_back();
    test_end();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
